// File: rtl/gearbox_fifo.sv
// Width-converting FIFO: each write pushes RATIO narrow words, each read pops one.
// First-word-fall-through head, registered status flags, sticky error flags, synchronous flush.
module gearbox_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int RATIO       = 2,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clr,
  input  logic                        wr,
  input  logic [RATIO*DATA_WIDTH-1:0] w_data,
  input  logic                        rd,
  output logic [DATA_WIDTH-1:0]       r_data,
  output logic                        empty,
  output logic                        full,
  output logic                        almost_full,
  output logic [ADDR_WIDTH:0]         count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [PW-1:0] RATIO_P  = PW'(RATIO);
  localparam logic [PW-1:0] FULL_TH  = PW'(DEPTH - RATIO);
  localparam logic [PW-1:0] AFULL_TH = PW'(AFULL_LEVEL);

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_ACTIVE = 2'd1,
    S_FULL   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  afull_q, afull_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic [PW-1:0]         next_count;
  logic                  wr_ok, rd_ok, mem_we;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign empty       = (state_q == S_EMPTY);
  assign full        = (state_q == S_FULL);
  assign almost_full = afull_q;
  assign overflow    = ovf_q;
  assign underflow   = udf_q;
  assign count       = wr_ptr_q - rd_ptr_q;
  assign r_data      = empty ? '0 : mem[rd_ptr_q[ADDR_WIDTH-1:0]];

  assign wr_ok  = wr & ~full;
  assign rd_ok  = rd & ~empty;
  assign mem_we = wr_ok & ~clr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    state_d  = state_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_ok)   wr_ptr_d = wr_ptr_q + RATIO_P;
      else if (wr) ovf_d    = 1'b1;
      if (rd_ok)   rd_ptr_d = rd_ptr_q + 1'b1;
      else if (rd) udf_d    = 1'b1;
    end
    // Modulo subtraction on the extra-bit pointers yields 0..DEPTH directly
    next_count = wr_ptr_d - rd_ptr_d;
    if (next_count == '0)          state_d = S_EMPTY;
    else if (next_count > FULL_TH) state_d = S_FULL;
    else                           state_d = S_ACTIVE;
    afull_d = (next_count >= AFULL_TH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is deliberately left out of reset; the head is masked while empty
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < RATIO; i++) begin
        mem[wr_ptr_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(i)] <= w_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_gearbox_fifo.sv
// Directed bench for gearbox_fifo (8-bit words, depth 16, ratio 2).
module tb_gearbox_fifo;

  logic        clk;
  logic        reset_n;
  logic        clr;
  logic        wr;
  logic [15:0] w_data;
  logic        rd;
  logic [7:0]  r_data;
  logic        empty;
  logic        full;
  logic        almost_full;
  logic [4:0]  count;
  logic        overflow;
  logic        underflow;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] q[$];

  gearbox_fifo #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (4),
    .RATIO      (2),
    .AFULL_LEVEL(12)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (clr),
    .wr         (wr),
    .w_data     (w_data),
    .rd         (rd),
    .r_data     (r_data),
    .empty      (empty),
    .full       (full),
    .almost_full(almost_full),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [15:0] d);
    wr = 1'b1;
    w_data = d;
    step();
    wr = 1'b0;
  endtask

  task automatic do_read();
    rd = 1'b1;
    step();
    rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int pushed;
    int popped;
    logic [7:0] nb;
    logic [7:0] nb1;

    reset_n = 1'b0;
    clr = 1'b0;
    wr = 1'b0;
    rd = 1'b0;
    w_data = '0;

    // 1. reset state
    #12;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_rdata", r_data, 8'h00);
    chk("rst_afull", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    reset_n = 1'b1;

    // 2. single write, two FWFT reads
    do_write(16'hBBAA);
    chk("t2_count", count, 2);
    chk("t2_empty", empty, 0);
    chk("t2_head0", r_data, 8'hAA);
    do_read();
    chk("t2_head1", r_data, 8'hBB);
    chk("t2_count1", count, 1);
    do_read();
    chk("t2_empty_after", empty, 1);
    chk("t2_rdata_empty", r_data, 8'h00);

    // 3. fill to full, overflow, contents intact
    for (int k = 0; k < 8; k++) begin
      do_write({8'h41 + 8'(2*k), 8'h40 + 8'(2*k)});
      if (k == 4) chk("t3_afull_at10", almost_full, 0);
      if (k == 5) chk("t3_afull_at12", almost_full, 1);
      if (k == 6) chk("t3_notfull_at14", full, 0);
    end
    chk("t3_full", full, 1);
    chk("t3_count", count, 16);
    chk("t3_afull", almost_full, 1);
    do_write(16'hDEAD);
    chk("t3_ovf", overflow, 1);
    chk("t3_count_ovf", count, 16);
    chk("t3_head_ovf", r_data, 8'h40);
    for (int k = 0; k < 16; k++) begin
      chk("t3_drain", r_data, 8'h40 + 8'(k));
      do_read();
    end
    chk("t3_empty", empty, 1);
    chk("t3_udf", underflow, 0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t3_clr_ovf", overflow, 0);

    // 4. interleaved stream across pointer wrap
    pushed = 0;
    popped = 0;
    nb = 8'h80;
    for (int it = 0; it < 300 && popped < 40; it++) begin
      bit dw;
      bit dr;
      dw = (pushed < 40) && (q.size() <= 14) && (it % 3 != 2);
      dr = (q.size() > 0) && ((it % 2 == 0) || (q.size() > 10));
      if (dr) chk("t4_head", r_data, q[0]);
      nb1 = nb + 8'd1;
      wr = dw;
      rd = dr;
      w_data = {nb1, nb};
      step();
      wr = 1'b0;
      rd = 1'b0;
      if (dr) begin
        void'(q.pop_front());
        popped++;
      end
      if (dw) begin
        q.push_back(nb);
        q.push_back(nb1);
        nb = nb + 8'd2;
        pushed += 2;
      end
      chk("t4_count", count, q.size());
    end
    chk("t4_popped", popped, 40);
    chk("t4_empty", empty, 1);
    chk("t4_no_err", {overflow, underflow}, 2'b00);

    // 5. simultaneous wr&rd at full and at empty, then flush
    for (int k = 0; k < 8; k++) do_write({8'h61 + 8'(2*k), 8'h60 + 8'(2*k)});
    do_read();
    chk("t5_count15", count, 15);
    chk("t5_full15", full, 1);
    wr = 1'b1;
    rd = 1'b1;
    w_data = 16'hEEEE;
    step();
    wr = 1'b0;
    rd = 1'b0;
    chk("t5_count14", count, 14);
    chk("t5_ovf", overflow, 1);
    chk("t5_full14", full, 0);
    chk("t5_head", r_data, 8'h62);
    for (int k = 0; k < 14; k++) do_read();
    chk("t5_drained", empty, 1);
    wr = 1'b1;
    rd = 1'b1;
    w_data = 16'h7170;
    step();
    wr = 1'b0;
    rd = 1'b0;
    chk("t5_count2", count, 2);
    chk("t5_udf", underflow, 1);
    chk("t5_head_new", r_data, 8'h70);
    clr = 1'b1;
    wr = 1'b1;
    rd = 1'b1;
    w_data = 16'h9999;
    step();
    clr = 1'b0;
    wr = 1'b0;
    rd = 1'b0;
    chk("t5_clr_count", count, 0);
    chk("t5_clr_flags", {overflow, underflow}, 2'b00);
    chk("t5_clr_empty", empty, 1);

    // 6. asynchronous reset between edges
    do_write(16'h5150);
    do_write(16'h5352);
    chk("t6_pre_count", count, 4);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_empty", empty, 1);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_rdata", r_data, 8'h00);
    #2;
    reset_n = 1'b1;
    do_write(16'h2211);
    chk("t6_count", count, 2);
    chk("t6_head0", r_data, 8'h11);
    do_read();
    chk("t6_head1", r_data, 8'h22);
    do_read();
    chk("t6_empty", empty, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
